// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART tx byte channel among NUM_REQ streams.
// Latency: req_valid in IDLE -> grant next cycle -> tx_valid one cycle later; one byte/cycle while tx_ready high.
// Backpressure: owner's req_ready follows (!tx_valid || tx_ready); a stalled owner holds the channel indefinitely.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t                state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         owner;
    logic [PW-1:0]         win_idx;
    logic                  win_vld;
    logic [BW-1:0]         burst_cnt;
    logic                  own_vld;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  own_rdy;
    logic                  beat;
    logic                  release_now;

    function automatic logic [PW-1:0] rot(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Scan from the far end so the requester closest to rr_ptr is written last and wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rot(rr_ptr, k)]) begin
                win_vld = 1'b1;
                win_idx = rot(rr_ptr, k);
            end
        end
    end

    always_comb begin
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == PW'(i)) begin
                own_vld  = req_valid[i];
                own_last = req_last[i];
                own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign own_rdy     = (state == LOCK) && (!tx_valid || tx_ready);
    assign beat        = own_rdy && own_vld;
    assign release_now = beat && (own_last || (burst_cnt == BW'(MAX_BURST - 1)));
    assign req_ready   = own_rdy ? grant : '0;
    assign busy        = (state == LOCK) || tx_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            grant     <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
        end else begin
            // Load and drain share an edge, so a full register still takes a byte when tx_ready is high.
            if (beat) begin
                tx_valid <= 1'b1;
                tx_data  <= own_data;
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state     <= LOCK;
                        owner     <= win_idx;
                        grant     <= NUM_REQ'(1) << win_idx;
                        burst_cnt <= '0;
                    end
                end
                LOCK: begin
                    if (release_now) begin
                        state     <= IDLE;
                        grant     <= '0;
                        burst_cnt <= '0;
                        rr_ptr    <= (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
                    end else if (beat) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations plus random traffic vs. a transaction-level model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic [N-1:0]    grant;
    logic            busy;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: owner index (-1 when nobody holds the channel), bytes sent in this grant, one-deep output slot.
    int          m_owner;
    int          m_rr;
    int          m_sent;
    bit          m_ov;
    logic [7:0]  m_od;
    int          m_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_sent = 0; m_ov = 0; m_od = 8'h00; m_acc = -1;
    endtask

    task automatic model_step(input bit rdy);
        bit got_beat;
        got_beat = 0;
        m_acc = -1;
        if (m_owner >= 0 && rdy && req_valid[m_owner]) got_beat = 1;
        if (got_beat) begin
            m_ov = 1;
            m_od = req_data[m_owner*DW +: DW];
        end else if (m_ov && tx_ready) begin
            m_ov = 0;
        end
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req_valid[(m_rr + k) % N]) begin
                    m_owner = (m_rr + k) % N;
                    m_sent = 0;
                end
            end
        end else if (got_beat) begin
            m_acc = m_owner;
            m_sent++;
            if (req_last[m_owner] || m_sent == MB) begin
                m_rr = (m_owner + 1) % N;
                m_owner = -1;
                m_sent = 0;
            end
        end
    endtask

    // Called at a falling edge with inputs already driven; compares, advances the model, returns at the next falling edge.
    task automatic cycle();
        logic [N-1:0] eg;
        bit rdy;
        #1;
        eg  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        rdy = (m_owner >= 0) && (!m_ov || tx_ready);
        chk("grant", grant, eg);
        chk("req_ready", req_ready, rdy ? eg : '0);
        chk("tx_valid", tx_valid, m_ov);
        chk("busy", busy, (m_owner >= 0) || m_ov);
        if (m_ov) chk("tx_data", tx_data, m_od);
        model_step(rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int rem[N];
    logic [7:0] byt[N];
    bit act[N];

    initial begin
        int n3;
        bit sent1, done;
        tx_ready = 1'b1;
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, three-byte packet.
        req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = '0;
        cycle();
        chk("t1_grant", grant, 4'b0001);
        cycle();
        chk("t1_d41", tx_data, 8'h41);
        req_data[7:0] = 8'h42;
        cycle();
        chk("t1_d42", tx_data, 8'h42);
        req_data[7:0] = 8'h43; req_last[0] = 1'b1;
        cycle();
        chk("t1_d43", tx_data, 8'h43);
        chk("t1_grant_rel", grant, 4'b0000);
        req_valid = '0; req_last = '0;
        cycle();
        // rr_ptr now 1: with 0 and 1 both requesting, 1 must win.
        req_valid = 4'b0011; req_last = 4'b0011; req_data[15:8] = 8'h11;
        cycle();
        chk("t1_rr_next", grant, 4'b0010);
        req_valid = '0;
        cycle();
        cycle();

        // Three requesters with one-byte packets from rr_ptr=0.
        do_reset();
        req_valid = 4'b0111; req_last = 4'b0111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int j = 0; j < 4; j++) begin
            chk("t2_idle", grant, 4'b0000);
            cycle();
            chk("t2_grant", grant, 4'(1 << (j % 3)));
            cycle();
            chk("t2_data", tx_data, 8'h10 + 8'(j % 3));
        end
        req_valid = '0; req_last = '0;
        cycle();
        cycle();

        // Forced release after MAX_BURST bytes with requester 1 waiting.
        n3 = 0; sent1 = 0; done = 0;
        got.delete();
        for (int c = 0; c < 200; c++) begin
            req_valid[3] = (n3 < 20);
            req_data[31:24] = 8'(8'h80 + n3);
            req_last[3] = (n3 == 19);
            req_valid[1] = (c > 0) && !sent1;
            req_data[15:8] = 8'hA1;
            req_last[1] = 1'b1;
            if (tx_valid && tx_ready) got.push_back(tx_data);
            cycle();
            if (m_acc == 3) n3++;
            if (m_acc == 1) sent1 = 1;
            if (n3 == 20 && sent1 && !m_ov) begin
                done = 1;
                break;
            end
        end
        chk("t3_done", done, 1);
        exp_q.delete();
        for (int j = 0; j < 16; j++) exp_q.push_back(8'(8'h80 + j));
        exp_q.push_back(8'hA1);
        for (int j = 16; j < 20; j++) exp_q.push_back(8'(8'h80 + j));
        chk("t3_count", 32'(got.size()), 21);
        for (int j = 0; j < 21 && j < got.size(); j++) chk("t3_byte", got[j], exp_q[j]);
        req_valid = '0; req_last = '0;
        cycle();

        // tx_ready stall holding 0x55.
        req_valid = 4'b0100; req_data[23:16] = 8'h55; req_last = '0;
        cycle();
        cycle();
        tx_ready = 1'b0; req_data[23:16] = 8'h66; req_last[2] = 1'b1;
        for (int s = 0; s < 5; s++) begin
            cycle();
            chk("t4_hold_data", tx_data, 8'h55);
            chk("t4_hold_vld", tx_valid, 1);
            chk("t4_hold_rdy", req_ready, 4'b0000);
        end
        tx_ready = 1'b1;
        #1;
        chk("t4_rdy_rise", req_ready, 4'b0100);
        cycle();
        chk("t4_next", tx_data, 8'h66);
        req_valid = '0; req_last = '0;
        cycle();
        cycle();

        // Asynchronous reset with a byte pending.
        req_valid = 4'b0001; req_data[7:0] = 8'h77; tx_ready = 1'b0;
        cycle();
        cycle();
        chk("t5_pre_vld", tx_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_tx_valid", tx_valid, 0);
        chk("t5_grant", grant, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_busy", busy, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        req_valid = 4'b0101; req_last = 4'b0101; req_data[7:0] = 8'h78; req_data[23:16] = 8'h2A;
        cycle();
        chk("t5_restart", grant, 4'b0001);
        cycle();
        chk("t5_data", tx_data, 8'h78);
        req_valid = '0; req_last = '0;
        cycle();
        cycle();

        // Owner pauses mid-packet while requester 3 waits.
        req_valid = 4'b1010; req_last = 4'b1000; req_data[15:8] = 8'h31; req_data[31:24] = 8'h3F;
        cycle();
        chk("t6_grant", grant, 4'b0010);
        cycle();
        req_valid[1] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("t6_hold_grant", grant, 4'b0010);
        end
        chk("t6_no_beat", tx_valid, 0);
        req_valid[1] = 1'b1; req_data[15:8] = 8'h32; req_last[1] = 1'b1;
        #1;
        chk("t6_resume_rdy", req_ready, 4'b0010);
        cycle();
        chk("t6_resume_data", tx_data, 8'h32);
        chk("t6_release", grant, 4'b0000);
        req_valid = 4'b1000;
        cycle();
        chk("t6_next_owner", grant, 4'b1000);
        cycle();
        req_valid = '0; req_last = '0;
        cycle();

        // Random traffic.
        for (int i = 0; i < N; i++) begin
            rem[i] = $urandom_range(1, 24);
            byt[i] = 8'($urandom);
            act[i] = 1;
        end
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0)
                for (int i = 0; i < N; i++) act[i] = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                req_valid[i] = act[i] && (($urandom % 4) != 0);
                req_data[i*DW +: DW] = byt[i];
                req_last[i] = (rem[i] == 1);
            end
            tx_ready = ($urandom % 3) != 0;
            cycle();
            if (m_acc >= 0) begin
                byt[m_acc] = byt[m_acc] + 8'd1;
                rem[m_acc]--;
                if (rem[m_acc] == 0) rem[m_acc] = $urandom_range(1, 24);
            end
        end
        req_valid = '0; req_last = '0; tx_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
